mux4x1_rr: RTL and testbench
============================

# mux4x1_rr

Four-channel round-robin multiplexer that merges four valid/ready input streams onto one output stream. Each output beat carries a 2-bit channel tag `out_sel`. It is the gathering end of the `dmux1x4` routing path: a downstream `dmux1x4` driven with `Sel = out_sel` and `D = out_data` returns every beat to its originating lane. Arbitration is fair round-robin, and the output is fully registered.

## Interface
- `WIDTH`, default 8: data width per channel, ≥ 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 4: per-channel valid; bit i belongs to channel i.
- `in_data` input 4*WIDTH: channel i data at bits [i*WIDTH +: WIDTH].
- `in_ready` output 4: per-channel ready, one-hot or zero.
- `out_valid` output 1: output beat present.
- `out_data` output WIDTH: data of the output beat.
- `out_sel` output 2: channel index of the output beat.
- `out_ready` input 1: downstream accepts the beat.

## Operation
- **Transfer rules**
  - Input transfer on channel i occurs when `in_valid[i] & in_ready[i]` at a clock edge.
  - Output transfer occurs when `out_valid & out_ready`.
- **Load enable:** `load_en = !out_valid | out_ready`. The output register can accept a new beat when it is empty or being drained in the same cycle.
- **Priority pointer:** 2-bit `ptr`, reset 0.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first channel in that order with `in_valid` high is the grant `g`.
- **Ready generation**
  - `in_ready[g] = load_en` when any `in_valid` is set; all other `in_ready` bits are 0.
  - With no valid inputs, `in_ready = 4'b0000`.
  - `in_ready` is combinational from `in_valid`, `ptr`, `out_valid` and `out_ready`. It must not depend on `in_data`.
- **On an input transfer from channel g**
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= g+1` mod 4; from g=3 it wraps to 0.
- **Output-only transfer:** an output transfer with no input transfer gives `out_valid <= 0`; `out_data` and `out_sel` keep their last values.
- **Simultaneous transfers:** an output transfer and an input transfer in the same cycle replace the beat. `out_valid` stays 1, so full throughput is one beat per cycle.
- **Stall:** while `out_valid & !out_ready`, `out_data`, `out_sel`, `out_valid` and `ptr` hold, and `in_ready` is all 0.
- **Data integrity:** no beat is duplicated or dropped.
- **Arbitration fairness:** a channel that holds `in_valid` waits at most 3 other grants.

## Timing
- **Reset values**
  - Asserting `rst_n` low clears immediately, without waiting for a clock: `out_valid = 0`, `out_data = 0`, `out_sel = 2'b00`, `ptr = 0`.
  - Hence `in_ready = 0000` when no inputs are valid.
- **Reset mid-operation:** a held beat is discarded. No transfer completes at an edge during which `rst_n` is low.
- **After reset release:** the first grant search starts at channel 0.
- **Latency:** 1 cycle from an input transfer to `out_valid`/`out_data` visible.
- **Throughput:** 1 beat/cycle with `out_ready` held high and any input valid.
- **Pointer wrap:** `ptr` only advances on an input transfer. From 3 it wraps to 0.

## Test plan
- **Reset:** drive `rst_n = 0` mid-cycle with `out_valid = 1` -> `out_valid = 0`, `out_sel = 00`, `out_data = 0` before the next edge. After release with `in_valid = 1111`, the first grant is channel 0.
- **Round-robin:** `in_valid = 1111`, data ch0..ch3 = 0xA0, 0xA1, 0xA2, 0xA3, `out_ready = 1` -> `out_sel` sequence is 0,1,2,3,0 on consecutive cycles with matching data; one beat per cycle.
- **Wrap and skip:** only ch3 and ch0 valid, `ptr = 0` -> grants 0,3,0,3. Then with only ch2 valid, the grant is 2 and `ptr` becomes 3.
- **Backpressure:** with `out_valid = 1`, `out_sel = 1`, `out_data = 0x55`, hold `out_ready = 0` for 5 cycles -> outputs stable, `in_ready = 0000`, `ptr` unchanged. Releasing `out_ready` accepts the next beat in the same cycle.
- **Idle drain:** single beat from ch2 = 0x3C, then `in_valid = 0000` -> one cycle of `out_valid = 1`, `out_sel = 2`, `out_data = 0x3C`, then `out_valid = 0` with `out_data` held.
- **Loopback:** connect the bit 0 path of `out_data` (WIDTH = 1) and `out_sel` to `dmux1x4` `D` and `Sel`, driving 1s on all channels -> the `dmux1x4` `Y` bit equal to `out_sel` is 1 on every beat; the other `Y` bits are 0.

Source files
------------

// File: rtl/mux4x1_rr.sv
// rtl/mux4x1_rr.sv - four-channel round-robin merge of valid/ready streams with a registered, channel-tagged output
module mux4x1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  // Channel that heads the search order; advances past each granted channel.
  logic [1:0]       ptr;
  logic [1:0]       gnt;
  logic             any_valid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;

  // The output register can take a beat when it is empty or draining this cycle.
  assign load_en = !out_valid | out_ready;
  assign xfer    = any_valid & load_en;

  // Rotating priority search: first valid channel starting at ptr, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    gnt       = ptr;
    any_valid = 1'b0;
    idx       = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!any_valid && in_valid[idx]) begin
        gnt       = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Ready goes only to the granted channel, and only when the output can load.
  always_comb begin
    in_ready = 4'b0000;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  // Data select depends only on the grant, keeping in_ready independent of in_data.
  always_comb begin
    gnt_data = in_data[WIDTH-1:0];
    for (int k = 0; k < 4; k++) begin
      if (gnt == k[1:0]) gnt_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output beat register and pointer: load on an input transfer, empty on a lone drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'b00;
      ptr       <= 2'b00;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt;
      ptr       <= gnt + 2'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4x1_rr.sv
// tb/tb_mux4x1_rr.sv - self-checking bench for mux4x1_rr with directed scenarios and a randomized reference model
module tb_mux4x1_rr;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  mux4x1_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abcd();
    for (int i = 0; i < 4; i++) in_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
  endtask

  task automatic do_reset();
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b0000; in_data = '0; out_ready = 1'b0;
    #3;
    total_cnt++;
    if (out_valid !== 1'b0 || out_sel !== 2'b00 || out_data !== 8'h00 || in_ready !== 4'b0000)
      $display("FAIL reset_init got v=%b s=%0d d=%h r=%b exp v=0 s=0 d=00 r=0000", out_valid, out_sel, out_data, in_ready);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 4'b0100; in_data[2*WIDTH +: WIDTH] = 8'h77;
    tick();
    in_valid = 4'b0000;
    total_cnt++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h77)
      $display("FAIL reset_preload got v=%b s=%0d d=%h exp v=1 s=2 d=77", out_valid, out_sel, out_data);
    else pass_cnt++;
    #2; rst_n = 1'b0; #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_sel !== 2'b00 || out_data !== 8'h00)
      $display("FAIL reset_async got v=%b s=%0d d=%h exp v=0 s=0 d=00", out_valid, out_sel, out_data);
    else pass_cnt++;
    in_valid = 4'b1111; set_abcd(); out_ready = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_no_xfer got v=%b exp v=0", out_valid);
    else pass_cnt++;
    rst_n = 1'b1;
    #3;
    total_cnt++;
    if (in_ready !== 4'b0001)
      $display("FAIL reset_first_ready got %b exp 0001", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0)
      $display("FAIL reset_first_grant got v=%b s=%0d d=%h exp v=1 s=0 d=a0", out_valid, out_sel, out_data);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 4'b1111; set_abcd(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      total_cnt++;
      if (in_ready !== (4'b0001 << (i % 4)))
        $display("FAIL rr_ready cyc%0d got %b exp %b", i, in_ready, 4'b0001 << (i % 4));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'hA0 + 8'(i % 4))
        $display("FAIL rr_beat cyc%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", i, out_valid, out_sel, out_data, i % 4, 8'hA0 + 8'(i % 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_skip();
    int exp_g [4] = '{0, 3, 0, 3};
    do_reset();
    in_valid = 4'b1001; set_abcd(); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_sel !== 2'(exp_g[i]) || out_data !== 8'hA0 + 8'(exp_g[i]))
        $display("FAIL wrap_grant cyc%0d got s=%0d d=%h exp s=%0d", i, out_sel, out_data, exp_g[i]);
      else pass_cnt++;
    end
    in_valid = 4'b0100;
    tick();
    total_cnt++;
    if (out_sel !== 2'd2 || out_data !== 8'hA2)
      $display("FAIL skip_only2 got s=%0d d=%h exp s=2 d=a2", out_sel, out_data);
    else pass_cnt++;
    in_valid = 4'b1111;
    tick();
    total_cnt++;
    if (out_sel !== 2'd3 || out_data !== 8'hA3)
      $display("FAIL skip_ptr3 got s=%0d d=%h exp s=3 d=a3", out_sel, out_data);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0010; in_data[1*WIDTH +: WIDTH] = 8'h55;
    tick();
    set_abcd(); in_data[1*WIDTH +: WIDTH] = 8'h55; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #3;
      total_cnt++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h55)
        $display("FAIL bp_hold cyc%0d got r=%b v=%b s=%0d d=%h exp r=0000 v=1 s=1 d=55", i, in_ready, out_valid, out_sel, out_data);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    #3;
    total_cnt++;
    if (in_ready !== 4'b0100)
      $display("FAIL bp_release_ready got %b exp 0100", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hA2)
      $display("FAIL bp_release_beat got v=%b s=%0d d=%h exp v=1 s=2 d=a2", out_valid, out_sel, out_data);
    else pass_cnt++;
  endtask

  task automatic test_idle_drain();
    do_reset();
    out_ready = 1'b1; in_valid = 4'b0100; in_data[2*WIDTH +: WIDTH] = 8'h3C;
    tick();
    in_valid = 4'b0000;
    total_cnt++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h3C)
      $display("FAIL drain_beat got v=%b s=%0d d=%h exp v=1 s=2 d=3c", out_valid, out_sel, out_data);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || out_sel !== 2'd2 || out_data !== 8'h3C || in_ready !== 4'b0000)
        $display("FAIL drain_idle cyc%0d got v=%b s=%0d d=%h r=%b exp v=0 s=2 d=3c r=0000", i, out_valid, out_sel, out_data, in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_loopback();
    logic [3:0] y;
    do_reset();
    in_data = '1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      y = 4'b0000;
      y[out_sel] = out_data[0];
      total_cnt++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || y !== (4'b0001 << (i % 4)))
        $display("FAIL loopback cyc%0d got v=%b s=%0d y=%b exp v=1 s=%0d y=%b", i, out_valid, out_sel, y, i % 4, 4'b0001 << (i % 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int         m_ptr;
    logic       m_ov;
    logic [7:0] m_od;
    logic [1:0] m_os;
    logic [3:0] pend;
    logic [7:0] pd [4];
    int         wt [4];
    int         g;
    logic [3:0] exp_ready;
    do_reset();
    m_ptr = 0; m_ov = 1'b0; m_od = 8'h00; m_os = 2'd0; pend = 4'b0000;
    for (int c = 0; c < 4; c++) begin pd[c] = 8'h00; wt[c] = 0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pend[c] && ($urandom_range(1, 0) == 1)) begin
          pend[c] = 1'b1;
          pd[c]   = 8'($urandom);
        end
        in_data[c*WIDTH +: WIDTH] = pd[c];
      end
      in_valid  = pend;
      out_ready = ($urandom_range(3, 0) != 0);
      #3;
      g = -1;
      for (int k = 0; k < 4; k++) if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      exp_ready = (g >= 0 && (!m_ov || out_ready)) ? (4'b0001 << g) : 4'b0000;
      total_cnt++;
      if (in_ready !== exp_ready || out_valid !== m_ov || out_sel !== m_os || out_data !== m_od)
        $display("FAIL rand cyc%0d got r=%b v=%b s=%0d d=%h exp r=%b v=%b s=%0d d=%h", cyc, in_ready, out_valid, out_sel, out_data, exp_ready, m_ov, m_os, m_od);
      else pass_cnt++;
      if (exp_ready != 4'b0000) begin
        for (int c = 0; c < 4; c++) if (c != g && pend[c]) wt[c]++;
        total_cnt++;
        if (wt[g] > 3)
          $display("FAIL rand_fair cyc%0d ch%0d waited %0d grants exp <=3", cyc, g, wt[g]);
        else pass_cnt++;
        wt[g] = 0;
      end
      tick();
      if (exp_ready != 4'b0000) begin
        m_ov = 1'b1; m_od = pd[g]; m_os = 2'(g); m_ptr = (g + 1) % 4; pend[g] = 1'b0;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_backpressure();
    test_idle_drain();
    test_loopback();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
